// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the mem_EN / mem_RW / MFC handshake.
// Captures a request, waits LATENCY cycles, performs the access on an internal
// word array and raises MFC until the initiator drops mem_EN.
//
// state  | meaning
// IDLE   | waiting for mem_EN; request fields captured on the accepting edge
// ACCESS | wait-state countdown; dropping mem_EN here aborts the access
// DONE   | access complete, MFC/addr_err/mem_rdata held until mem_EN drops
module mem_responder #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_EN,
  input  logic              mem_RW,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              MFC,
  output logic              addr_err,
  output logic              busy
);

  localparam int         DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_V = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_rw;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [3:0]            r_cnt;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_mfc;
  logic                  r_addr_err;
  logic [DATA_W-1:0]     r_mem [0:DEPTH-1];

  logic                  w_capture;
  logic                  w_dec;
  logic                  w_complete;
  logic                  w_release;
  logic                  w_oor;
  logic [DEPTH_LOG2-1:0] w_idx;

  // Any captured address bit above the implemented range flags an error.
  assign w_oor = |r_addr[ADDR_W-1:DEPTH_LOG2];
  assign w_idx = r_addr[DEPTH_LOG2-1:0];

  assign mem_rdata = r_rdata;
  assign MFC       = r_mfc;
  assign addr_err  = r_addr_err;
  assign busy      = (r_state != S_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and one-cycle action strobes.
  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_dec      = 1'b0;
    w_complete = 1'b0;
    w_release  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_EN) begin
          w_capture = 1'b1;
          w_next    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!mem_EN) begin
          w_next = S_IDLE;
        end else if (r_cnt != 4'd0) begin
          w_dec = 1'b1;
        end else begin
          w_complete = 1'b1;
          w_next     = S_DONE;
        end
      end
      S_DONE: begin
        if (!mem_EN) begin
          w_release = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request holding registers and wait-state counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= 4'd0;
    end else if (w_capture) begin
      r_rw    <= mem_RW;
      r_addr  <= mem_addr;
      r_wdata <= mem_wdata;
      r_cnt   <= LAT_V;
    end else if (w_dec) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Registered response: MFC, addr_err and load data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mfc      <= 1'b0;
      r_addr_err <= 1'b0;
      r_rdata    <= '0;
    end else if (w_complete) begin
      r_mfc      <= 1'b1;
      r_addr_err <= w_oor;
      if (r_rw) begin
        r_rdata <= w_oor ? '0 : r_mem[w_idx];
      end
    end else if (w_release) begin
      r_mfc      <= 1'b0;
      r_addr_err <= 1'b0;
    end
  end

  // Word array; not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_complete && !r_rw && !w_oor) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed scenarios plus randomized accesses
// checked against an array model of the memory.
module tb_mem_responder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_EN;
  logic        mem_RW;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        MFC;
  logic        addr_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] ref_mem [0:255];
  bit          known   [0:255];
  logic [15:0] ref_rdata;

  mem_responder #(
    .DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .mem_EN(mem_EN), .mem_RW(mem_RW),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .MFC(MFC), .addr_err(addr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: memory of 256 words, anything at or above 256 is an error.
  task automatic model(input logic rw, input logic [15:0] a, input logic [15:0] d,
                       output logic [15:0] exp_rd, output logic exp_err);
    exp_err = (a > 16'd255);
    if (rw) begin
      ref_rdata = exp_err ? 16'h0000 : ref_mem[a[7:0]];
    end else if (!exp_err) begin
      ref_mem[a[7:0]] = d;
      known[a[7:0]]   = 1'b1;
    end
    exp_rd = ref_rdata;
  endtask

  // Issue a request (called at posedge+1) and count edges after capture until MFC.
  task automatic access(input logic rw, input logic [15:0] a, input logic [15:0] d,
                        input bit disturb, output int cyc, output logic [15:0] rd,
                        output logic er);
    mem_EN = 1'b1; mem_RW = rw; mem_addr = a; mem_wdata = d;
    @(posedge clk); #1;
    cyc = 0;
    while (MFC !== 1'b1 && cyc < 40) begin
      if (disturb) begin
        mem_addr = 16'($urandom); mem_wdata = 16'($urandom); mem_RW = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    rd = mem_rdata;
    er = addr_err;
  endtask

  task automatic release_req();
    mem_EN = 1'b0; mem_RW = 1'($urandom); mem_wdata = 16'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic setup_write(input logic [15:0] a, input logic [15:0] d);
    int cyc; logic [15:0] rd; logic er; logic [15:0] xr; logic xe;
    access(1'b0, a, d, 1'b0, cyc, rd, er);
    model(1'b0, a, d, xr, xe);
    release_req();
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_EN = 1'b0; mem_RW = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (MFC !== 1'b0) begin errors++; $display("FAIL reset_mfc got=%b exp=0", MFC); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", addr_err); end
    checks++; if (mem_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", mem_rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    ref_rdata = 16'h0000;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    int cyc; logic [15:0] rd; logic er; logic [15:0] xr; logic xe;
    access(1'b0, 16'h0012, 16'hBEEF, 1'b0, cyc, rd, er);
    model(1'b0, 16'h0012, 16'hBEEF, xr, xe);
    checks++; if (cyc !== LAT + 1) begin errors++; $display("FAIL store_latency got=%0d exp=%0d", cyc, LAT + 1); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL store_err got=%b exp=0", er); end
    release_req();
    checks++; if (MFC !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL store_release mfc=%b busy=%b exp=0/0", MFC, busy); end
    access(1'b1, 16'h0012, 16'h0000, 1'b0, cyc, rd, er);
    model(1'b1, 16'h0012, 16'h0000, xr, xe);
    checks++; if (cyc !== LAT + 1) begin errors++; $display("FAIL load_latency got=%0d exp=%0d", cyc, LAT + 1); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL load_data got=%h exp=beef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_err got=%b exp=0", er); end
    release_req();
  endtask

  task automatic test_held();
    int cyc; logic [15:0] rd; logic er; logic [15:0] xr; logic xe;
    access(1'b1, 16'h0012, 16'h0000, 1'b0, cyc, rd, er);
    model(1'b1, 16'h0012, 16'h0000, xr, xe);
    checks++; if (rd !== xr) begin errors++; $display("FAIL held_data got=%h exp=%h", rd, xr); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (MFC !== 1'b1 || mem_rdata !== xr) begin
        errors++; $display("FAIL held_stable cycle=%0d mfc=%b rdata=%h exp=1/%h", i, MFC, mem_rdata, xr);
      end
    end
    release_req();
    checks++; if (MFC !== 1'b0 || mem_rdata !== xr) begin
      errors++; $display("FAIL held_release mfc=%b rdata=%h exp=0/%h", MFC, mem_rdata, xr);
    end
    access(1'b1, 16'h0012, 16'h0000, 1'b0, cyc, rd, er);
    model(1'b1, 16'h0012, 16'h0000, xr, xe);
    checks++; if (cyc !== LAT + 1) begin errors++; $display("FAIL held_fresh_latency got=%0d exp=%0d", cyc, LAT + 1); end
    release_req();
  endtask

  task automatic test_abort();
    int cyc; logic [15:0] rd; logic er; logic [15:0] xr; logic xe; bit seen;
    setup_write(16'h0005, 16'h0000);
    mem_EN = 1'b1; mem_RW = 1'b0; mem_addr = 16'h0005; mem_wdata = 16'h1234;
    @(posedge clk); #1;
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (MFC === 1'b1) seen = 1;
    end
    mem_EN = 1'b0;
    @(posedge clk); #1;
    if (MFC === 1'b1) seen = 1;
    repeat (3) begin
      @(posedge clk); #1;
      if (MFC === 1'b1) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL abort_mfc got=1 exp=never"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    access(1'b1, 16'h0005, 16'h0000, 1'b0, cyc, rd, er);
    model(1'b1, 16'h0005, 16'h0000, xr, xe);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL abort_readback got=%h exp=0000", rd); end
    release_req();
  endtask

  task automatic test_out_of_range();
    int cyc; logic [15:0] rd; logic er; logic [15:0] xr; logic xe;
    setup_write(16'h0000, 16'h1111);
    access(1'b1, 16'h0000, 16'h0000, 1'b0, cyc, rd, er);
    model(1'b1, 16'h0000, 16'h0000, xr, xe);
    release_req();
    access(1'b1, 16'h0100, 16'h0000, 1'b0, cyc, rd, er);
    model(1'b1, 16'h0100, 16'h0000, xr, xe);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_read_err got=%b exp=1", er); end
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL oor_read_data got=%h exp=0000", rd); end
    release_req();
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL oor_err_clear got=%b exp=0", addr_err); end
    access(1'b1, 16'h0000, 16'h0000, 1'b0, cyc, rd, er);
    model(1'b1, 16'h0000, 16'h0000, xr, xe);
    release_req();
    access(1'b0, 16'h0100, 16'hAAAA, 1'b0, cyc, rd, er);
    model(1'b0, 16'h0100, 16'hAAAA, xr, xe);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_write_err got=%b exp=1", er); end
    checks++; if (rd !== xr) begin errors++; $display("FAIL oor_write_rdata got=%h exp=%h", rd, xr); end
    release_req();
    access(1'b1, 16'h0000, 16'h0000, 1'b0, cyc, rd, er);
    model(1'b1, 16'h0000, 16'h0000, xr, xe);
    checks++; if (rd !== 16'h1111) begin errors++; $display("FAIL oor_no_alias got=%h exp=1111", rd); end
    release_req();
  endtask

  task automatic test_reset_mid();
    int cyc; logic [15:0] rd; logic er; logic [15:0] xr; logic xe;
    setup_write(16'h0007, 16'h0777);
    access(1'b1, 16'h0007, 16'h0000, 1'b0, cyc, rd, er);
    model(1'b1, 16'h0007, 16'h0000, xr, xe);
    release_req();
    mem_EN = 1'b1; mem_RW = 1'b0; mem_addr = 16'h0007; mem_wdata = 16'h5555;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++; if (MFC !== 1'b0 || busy !== 1'b0 || mem_rdata !== 16'h0000) begin
      errors++; $display("FAIL rst_access mfc=%b busy=%b rdata=%h exp=0/0/0000", MFC, busy, mem_rdata);
    end
    @(posedge clk); #1;
    mem_EN = 1'b0;
    rst = 1'b0;
    ref_rdata = 16'h0000;
    @(posedge clk); #1;
    access(1'b1, 16'h0007, 16'h0000, 1'b0, cyc, rd, er);
    model(1'b1, 16'h0007, 16'h0000, xr, xe);
    checks++; if (rd !== 16'h0777) begin errors++; $display("FAIL rst_discard got=%h exp=0777", rd); end
    release_req();
    access(1'b0, 16'h0009, 16'h9999, 1'b0, cyc, rd, er);
    model(1'b0, 16'h0009, 16'h9999, xr, xe);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (MFC !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_done mfc=%b busy=%b exp=0/0", MFC, busy);
    end
    @(posedge clk); #1;
    mem_EN = 1'b0;
    rst = 1'b0;
    ref_rdata = 16'h0000;
    @(posedge clk); #1;
    access(1'b1, 16'h0009, 16'h0000, 1'b0, cyc, rd, er);
    model(1'b1, 16'h0009, 16'h0000, xr, xe);
    checks++; if (rd !== 16'h9999) begin errors++; $display("FAIL rst_committed got=%h exp=9999", rd); end
    release_req();
  endtask

  task automatic test_disturb();
    int cyc; logic [15:0] rd; logic er; logic [15:0] xr; logic xe;
    access(1'b0, 16'h0033, 16'hC0DE, 1'b1, cyc, rd, er);
    model(1'b0, 16'h0033, 16'hC0DE, xr, xe);
    checks++; if (cyc !== LAT + 1 || er !== 1'b0) begin
      errors++; $display("FAIL disturb_write cyc=%0d err=%b exp=%0d/0", cyc, er, LAT + 1);
    end
    release_req();
    access(1'b1, 16'h0033, 16'h0000, 1'b1, cyc, rd, er);
    model(1'b1, 16'h0033, 16'h0000, xr, xe);
    checks++; if (rd !== 16'hC0DE || er !== 1'b0) begin
      errors++; $display("FAIL disturb_readback got=%h err=%b exp=c0de/0", rd, er);
    end
    release_req();
  endtask

  task automatic test_back_to_back();
    int cyc; logic [15:0] rd; logic er; logic [15:0] xr; logic xe;
    access(1'b0, 16'h0040, 16'h4040, 1'b0, cyc, rd, er);
    model(1'b0, 16'h0040, 16'h4040, xr, xe);
    release_req();
    access(1'b0, 16'h0041, 16'h4141, 1'b0, cyc, rd, er);
    model(1'b0, 16'h0041, 16'h4141, xr, xe);
    checks++; if (cyc !== LAT + 1) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", cyc, LAT + 1); end
    release_req();
    access(1'b1, 16'h0041, 16'h0000, 1'b0, cyc, rd, er);
    model(1'b1, 16'h0041, 16'h0000, xr, xe);
    checks++; if (rd !== 16'h4141) begin errors++; $display("FAIL b2b_raw got=%h exp=4141", rd); end
    release_req();
    access(1'b1, 16'h0040, 16'h0000, 1'b0, cyc, rd, er);
    model(1'b1, 16'h0040, 16'h0000, xr, xe);
    checks++; if (rd !== 16'h4040) begin errors++; $display("FAIL b2b_first got=%h exp=4040", rd); end
    release_req();
  endtask

  task automatic test_random();
    int cyc; logic [15:0] rd; logic er; logic [15:0] xr; logic xe;
    logic rw; logic [15:0] a; logic [15:0] d;
    for (int n = 0; n < 40; n++) begin
      rw = 1'($urandom_range(0, 1));
      d  = 16'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        a = 16'd256 + 16'($urandom_range(0, 65279));
      end else begin
        a = 16'($urandom_range(0, 255));
        if (rw && !known[a[7:0]]) rw = 1'b0;
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      access(rw, a, d, 1'b0, cyc, rd, er);
      model(rw, a, d, xr, xe);
      checks++; if (cyc !== LAT + 1 || er !== xe || rd !== xr) begin
        errors++;
        $display("FAIL rand_%0d rw=%b addr=%h cyc=%0d err=%b rdata=%h exp=%0d/%b/%h",
                 n, rw, a, cyc, er, rd, LAT + 1, xe, xr);
      end
      release_req();
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_held();
    test_abort();
    test_out_of_range();
    test_reset_mid();
    test_disturb();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU load/store handshake (mem_EN / mem_RW / MFC).
- Captures the address driven from MAR and, on stores, the write data driven from MDR. Performs the access on an internal word array after a fixed wait-state latency, then asserts MFC.
- On loads, returns read data on mem_rdata for the MDR to latch.
- Sits between the MAR/MDR registers and the rest of the datapath, opposite the load/store control FSM.

Parameters:
- DATA_W, 16, data word width; matches the bus/MDR width.
- ADDR_W, 16, width of the address input (MAR width).
- DEPTH_LOG2, 8, log2 of the number of implemented words (256).
- LATENCY, 3, wait-state cycles between request capture and completion; legal range 0..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_EN  in  1  access request; held high by the initiator until MFC is seen.
- mem_RW  in  1  1 = read (load), 0 = write (store); sampled with the request.
- mem_addr  in  ADDR_W  word address from MAR.
- mem_wdata  in  DATA_W  store data from MDR.
- mem_rdata  out  DATA_W  load data; registered.
- MFC  out  1  memory function complete; registered.
- addr_err  out  1  set with MFC when the address is out of range; registered.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; MFC = 0, addr_err = 0, mem_rdata = 0, busy = 0, wait counter = 0.
  - Array contents are not cleared and hold their value across reset.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - On an edge with mem_EN = 1: capture mem_RW, mem_addr and mem_wdata into holding registers.
  - Load the counter with LATENCY and go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - If mem_EN = 0 at an edge, abort: go to IDLE; no write, no MFC, mem_rdata unchanged.
  - Else if counter != 0, decrement.
  - Else (counter == 0), complete the access, set MFC = 1, go to DONE.
  - Changes on mem_addr, mem_wdata and mem_RW during ACCESS are ignored; only the captured values are used.
- Completion edge:
  - Range check: if captured address bits [ADDR_W-1:DEPTH_LOG2] are nonzero, set addr_err = 1. No write is performed, and for a read mem_rdata is loaded with 0.
  - Otherwise addr_err = 0.
  - Write, in range: array[addr[DEPTH_LOG2-1:0]] <= captured wdata; mem_rdata unchanged.
  - Read, in range: mem_rdata <= array[addr[DEPTH_LOG2-1:0]].
- Latency: for a request first sampled at edge E0, MFC rises at edge E0+LATENCY+1. With LATENCY=3, MFC is high after the 4th edge following capture; with LATENCY=0, after the 1st.
- DONE:
  - MFC, addr_err and mem_rdata are held stable while mem_EN = 1. The initiator may keep mem_EN high for extra cycles while latching the MDR; no second access is started.
  - On an edge with mem_EN = 0: MFC = 0, addr_err = 0, go to IDLE. mem_rdata keeps the last read value.
- Back-to-back accesses: mem_EN must be sampled low at least once between requests. A new request is captured on the first edge mem_EN = 1 after returning to IDLE. Minimum access period is LATENCY+3 cycles.
- Reset mid-operation:
  - In ACCESS: the pending write is discarded; MFC never rises.
  - In DONE: MFC drops immediately; an already committed write persists.
- Read-after-write to the same address returns the new data, since the write commits before the next request can be captured.
- mem_RW and mem_wdata are don't-care whenever mem_EN = 0.

Test Plan:
- Store then load, LATENCY=3: write addr 0x0012, data 0xBEEF; MFC rises 4 edges after capture; drop mem_EN. Then read addr 0x0012 -> MFC after 4 edges, mem_rdata = 0xBEEF, addr_err = 0.
- Held request: read completes, mem_EN held 3 more cycles -> MFC stays 1 and mem_rdata stable. After mem_EN drops, MFC = 0 next edge; a fresh request starts a new 4-cycle wait.
- Abort: write 0x1234 to addr 0x0005 (prior content 0x0000), drop mem_EN after 2 cycles -> no MFC; subsequent read of 0x0005 returns 0x0000.
- Out of range: read addr 0x0100 -> MFC with addr_err = 1, mem_rdata = 0. Write 0x0100 with 0xAAAA -> addr_err = 1; read of addr 0x0000 is unchanged.
- Reset mid-access: assert rst during ACCESS of write 0x5555 to addr 0x0007 -> MFC/busy/mem_rdata = 0 asynchronously; later read of 0x0007 returns the old value.
- Input disturbance: change mem_addr and mem_wdata every cycle during ACCESS -> the captured address/data are used, verified by a readback.
